// File: rtl/mouse_sens_ctrl.sv
// mouse_sens_ctrl: bus-mapped sensitivity controller for the mouse transceiver.
// Holds a target sensitivity (0..3), set by software or the board buttons, and
// steps the transceiver with single-cycle INC_SENS / RED_SENS pulses until its
// SENSITIVITY output matches the target.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   BUS_DATA/ADDR/WE    shared 8-bit processor bus (BUS_DATA tri-stated when idle)
//   BTN_INC, BTN_DEC    debounced button levels (rising edge = one step request)
//   SENSITIVITY         current sensitivity reported by the transceiver
//   INC_SENS, RED_SENS  one-cycle step pulses to the transceiver
//   BUSY, ERROR         sequence in progress / sticky failure-to-follow flag
//   IRQ_RAISE, IRQ_ACK  completion interrupt (only with MOUSE_SENS_IRQ_EN)
//
// Register map: BASE_ADDR   R: {BUSY, ERROR, 2'b00, target, SENSITIVITY}  W: target
//               BASE_ADDR+1 R: step_count                              W: clear ERROR
// Optional feature macro: MOUSE_SENS_IRQ_EN
module mouse_sens_ctrl #(
    parameter logic [7:0]  BASE_ADDR   = 8'hA6,
    parameter int unsigned WAIT_CYCLES = 16,
    parameter int unsigned MAX_RETRIES = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic       BTN_INC,
    input  logic       BTN_DEC,
    input  logic [1:0] SENSITIVITY,
    output logic       INC_SENS,
    output logic       RED_SENS,
    output logic       BUSY,
    output logic       ERROR
`ifdef MOUSE_SENS_IRQ_EN
    ,
    output logic       IRQ_RAISE,
    input  logic       IRQ_ACK
`endif
);

    localparam logic [7:0] CNT_ADDR  = BASE_ADDR + 8'd1;
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_PULSE, ST_WAIT} state_t;

    state_t     state;
    logic [1:0] target;
    logic [1:0] sens_prev;
    logic       dir_up;
    logic [7:0] wait_cnt;
    logic [2:0] retries;
    logic [7:0] step_count;
    logic       btn_inc_q;
    logic       btn_dec_q;
    logic       rd_en;
    logic [7:0] rd_data;

    logic       wr_ctrl;
    logic       wr_cnt;
    logic       rd_hit;
    logic       inc_edge;
    logic       dec_edge;
    logic       moved;
    logic [2:0] retries_nx;
    logic       unused_data;

    assign wr_ctrl  = BUS_WE && (BUS_ADDR == BASE_ADDR);
    assign wr_cnt   = BUS_WE && (BUS_ADDR == CNT_ADDR);
    assign rd_hit   = !BUS_WE && ((BUS_ADDR == BASE_ADDR) || (BUS_ADDR == CNT_ADDR));
    assign inc_edge = BTN_INC && !btn_inc_q;
    assign dec_edge = BTN_DEC && !btn_dec_q;

    assign BUS_DATA    = rd_en ? rd_data : 8'bz;
    assign unused_data = ^BUS_DATA[7:2];

    // Did the transceiver take exactly one step in the pulsed direction?
    always_comb begin
        moved = 1'b0;
        if (dir_up) moved = ({1'b0, SENSITIVITY} == ({1'b0, sens_prev} + 3'd1));
        else        moved = ({1'b0, SENSITIVITY} == ({1'b0, sens_prev} - 3'd1));
        retries_nx = moved ? 3'd0 : (retries + 3'd1);
    end

    // Step-sequencing FSM, target tracking, flags and registered bus read.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_SYNC;
            target     <= 2'd0;
            sens_prev  <= 2'd0;
            dir_up     <= 1'b0;
            wait_cnt   <= 8'd0;
            retries    <= 3'd0;
            step_count <= 8'd0;
            btn_inc_q  <= 1'b0;
            btn_dec_q  <= 1'b0;
            INC_SENS   <= 1'b0;
            RED_SENS   <= 1'b0;
            BUSY       <= 1'b0;
            ERROR      <= 1'b0;
            rd_en      <= 1'b0;
            rd_data    <= 8'd0;
`ifdef MOUSE_SENS_IRQ_EN
            IRQ_RAISE  <= 1'b0;
`endif
        end else begin
            btn_inc_q <= BTN_INC;
            btn_dec_q <= BTN_DEC;
            INC_SENS  <= 1'b0;
            RED_SENS  <= 1'b0;

            // Clears come first so a same-cycle set overrides them.
            if (wr_cnt) ERROR <= 1'b0;
`ifdef MOUSE_SENS_IRQ_EN
            if (IRQ_ACK) IRQ_RAISE <= 1'b0;
`endif

            case (state)
                ST_SYNC: begin
                    target <= SENSITIVITY;
                    BUSY   <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (target != SENSITIVITY) begin
                        BUSY  <= 1'b1;
                        state <= ST_PULSE;
                    end else begin
                        BUSY  <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    // Direction is decided here so late target changes are honoured.
                    if (target != SENSITIVITY) begin
                        INC_SENS  <= (target > SENSITIVITY);
                        RED_SENS  <= (target < SENSITIVITY);
                        dir_up    <= (target > SENSITIVITY);
                        sens_prev <= SENSITIVITY;
                        wait_cnt  <= WAIT_LOAD;
                        BUSY      <= 1'b1;
                        state     <= ST_WAIT;
                    end else begin
                        BUSY      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 8'd1;
                    BUSY     <= 1'b1;
                    // Counter reaches zero on this edge: judge the last step.
                    if (wait_cnt == 8'd1) begin
                        if (moved) step_count <= step_count + 8'd1;
                        retries <= retries_nx;
                        if (SENSITIVITY == target) begin
                            BUSY  <= 1'b0;
                            state <= ST_IDLE;
`ifdef MOUSE_SENS_IRQ_EN
                            IRQ_RAISE <= 1'b1;
`endif
                        end else if (retries_nx == RETRY_MAX) begin
                            ERROR   <= 1'b1;
                            target  <= SENSITIVITY;
                            retries <= 3'd0;
                            BUSY    <= 1'b0;
                            state   <= ST_IDLE;
`ifdef MOUSE_SENS_IRQ_EN
                            IRQ_RAISE <= 1'b1;
`endif
                        end else begin
                            state <= ST_PULSE;
                        end
                    end
                end
                default: state <= ST_SYNC;
            endcase

            // Software/button target updates; a bus write beats button edges.
            if (state != ST_SYNC) begin
                if (wr_ctrl) begin
                    target <= BUS_DATA[1:0];
                end else if (inc_edge && !dec_edge) begin
                    target <= (target == 2'd3) ? 2'd3 : (target + 2'd1);
                end else if (dec_edge && !inc_edge) begin
                    target <= (target == 2'd0) ? 2'd0 : (target - 2'd1);
                end
            end

            rd_en   <= rd_hit;
            rd_data <= (BUS_ADDR == BASE_ADDR) ? {BUSY, ERROR, 2'b00, target, SENSITIVITY}
                                               : step_count;
        end
    end

endmodule

// File: doc/mouse_sens_ctrl.md
Name: mouse_sens_ctrl

Overview:
Bus-mapped controller that sets the mouse transceiver's sensitivity from software and from the board buttons. It holds a target sensitivity (0..3) and drives single-cycle INC_SENS / RED_SENS step pulses into the transceiver until its SENSITIVITY output matches the target. It shares the 8-bit processor data bus with the other peripherals, decoding two addresses directly above the mouse register bank.

Parameters:
BASE_ADDR, 8'hA6, address of the control/status register; BASE_ADDR+1 is the step-count/clear register
WAIT_CYCLES, 16, cycles to wait after each step pulse before sampling SENSITIVITY (1..255)
MAX_RETRIES, 3, consecutive non-responding steps before ERROR is declared (1..7)

Ports:
CLK  input  1  system clock
RESET  input  1  reset
BUS_DATA  inout  8  shared processor data bus, tri-stated when not driving
BUS_ADDR  input  8  processor address
BUS_WE  input  1  processor write enable
BTN_INC  input  1  synchronised, debounced button level: raise sensitivity
BTN_DEC  input  1  synchronised, debounced button level: lower sensitivity
SENSITIVITY  input  2  current sensitivity reported by the transceiver
INC_SENS  output  1  one-cycle step-up pulse to the transceiver
RED_SENS  output  1  one-cycle step-down pulse to the transceiver
BUSY  output  1  high while a step sequence is in progress
ERROR  output  1  sticky flag: transceiver failed to follow the step pulses

Behaviour:
- Reset: RESET (synchronous, active-high) on CLK.
- Reset values: INC_SENS=0, RED_SENS=0, BUSY=0, ERROR=0, step_count=0, retries=0, BUS_DATA released (Z), state=SYNC.
- Reset mid-sequence: aborts on the next edge. No further pulses are issued.
- SYNC (one cycle): target <= SENSITIVITY, then go to IDLE.
- Target updates, evaluated every cycle in any state other than SYNC:
  - Bus write to BASE_ADDR: target <= BUS_DATA[1:0]. Other data bits are ignored.
  - Rising edge of BTN_INC: target <= min(target+1, 3).
  - Rising edge of BTN_DEC: target <= max(target-1, 0).
  - Both button edges in the same cycle: ignored.
  - Bus write and a button edge in the same cycle: the bus write wins.
- IDLE: if target != SENSITIVITY, go to PULSE. Otherwise stay.
- PULSE (one cycle):
  - Assert INC_SENS if target > SENSITIVITY, or RED_SENS if target < SENSITIVITY. Never both.
  - If target == SENSITIVITY, assert neither and return to IDLE.
  - On a pulse, latch sens_prev <= SENSITIVITY, load wait counter = WAIT_CYCLES, go to WAIT.
- WAIT: decrement the counter each cycle. At 0, evaluate in order:
  - If SENSITIVITY moved one step toward the pulse direction versus sens_prev: step_count <= step_count+1 (8-bit wrap), retries <= 0. Otherwise retries <= retries+1.
  - If SENSITIVITY == target: go to IDLE.
  - Else if retries (updated value) == MAX_RETRIES: ERROR <= 1, target <= SENSITIVITY, retries <= 0, go to IDLE.
  - Else: go to PULSE.
- Target changes during WAIT take effect at the next PULSE decision. Direction is recomputed there.
- BUSY = (state is PULSE or WAIT), registered, so it matches the state.
- ERROR stays set until a bus write to BASE_ADDR+1 (any data) or RESET. Tracking continues while ERROR=1.
- Bus read:
  - Registered, one-cycle latency. The drive enable is set the cycle after BUS_ADDR is in {BASE_ADDR, BASE_ADDR+1} with BUS_WE=0 and RESET=0. The bus is released otherwise.
  - BASE_ADDR reads {BUSY, ERROR, 2'b00, target[1:0], SENSITIVITY[1:0]}.
  - BASE_ADDR+1 reads step_count.
- Bus writes are sampled on the edge where BUS_WE=1 and the address matches. Writes to other addresses are ignored.

Optional Feature:
MOUSE_SENS_IRQ_EN:
- Defined: adds ports IRQ_RAISE (output, 1) and IRQ_ACK (input, 1).
  - IRQ_RAISE is set on the cycle the FSM returns from WAIT to IDLE (completion or error), and held until IRQ_ACK=1.
  - A set event and IRQ_ACK in the same cycle: set wins.
  - Reset value 0.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, SENSITIVITY=2 held -> after SYNC, read BASE_ADDR returns 8'h0A; BUSY=0, no pulses.
- SENSITIVITY=0, write 8'h03 to BASE_ADDR; model advances SENSITIVITY 1 cycle after each INC_SENS -> exactly 3 INC_SENS pulses spaced WAIT_CYCLES+1 apart, BUSY then 0, read BASE_ADDR+1 = 3, RED_SENS never high.
- SENSITIVITY=3, BTN_DEC rising edge twice (model responsive) -> 2 RED_SENS pulses, final SENSITIVITY=1, target=1; BTN_DEC edge at target=0 -> target stays 0.
- Model ignores pulses, target 1 from 0 -> exactly MAX_RETRIES(3) INC_SENS pulses, then ERROR=1, target=0, BUSY=0; write BASE_ADDR+1 -> ERROR=0.
- Bus write 8'h00 and BTN_INC edge in the same cycle with target=2 -> target=0; both button edges together -> target unchanged.
- RESET asserted during WAIT -> next cycle INC_SENS/RED_SENS/BUSY=0, bus released; with MOUSE_SENS_IRQ_EN, completion raises IRQ_RAISE until IRQ_ACK.
